// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a start/busy/done handshake; shifts run one bit per cycle.
// Define ALU_BARREL_SHIFT_EN to use a single-cycle barrel shifter instead (busy then never asserts).
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SLL  = 4'b0010,
        OP_SLT  = 4'b0011,
        OP_SLTU = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SRA  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_OR   = 4'b1000,
        OP_AND  = 4'b1001
    } op_e;

`ifndef ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DONE  = 2'd2
    } state_e;
`endif

    state_e             state;
    logic [WIDTH-1:0]   comb_res;
    logic               is_illegal;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = src_b[SHAMT_W-1:0];

`ifndef ALU_BARREL_SHIFT_EN
    logic               is_shift;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shift_step;
    logic [SHAMT_W-1:0] cnt;
    op_e                op;
`endif

    // Single-cycle result; in the iterative build a shift yields src_a here (the shamt=0 case).
    always_comb begin
        comb_res   = '0;
        is_illegal = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
        is_shift   = 1'b0;
`endif
        case (op_e'(alu_control))
            OP_ADD:  comb_res = src_a + src_b;
            OP_SUB:  comb_res = src_a - src_b;
            OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  comb_res = src_a ^ src_b;
            OP_OR:   comb_res = src_a | src_b;
            OP_AND:  comb_res = src_a & src_b;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL:  comb_res = src_a << shamt;
            OP_SRL:  comb_res = src_a >> shamt;
            OP_SRA:  comb_res = $unsigned($signed(src_a) >>> shamt);
`else
            OP_SLL, OP_SRL, OP_SRA: begin
                is_shift = 1'b1;
                comb_res = src_a;
            end
`endif
            default: is_illegal = 1'b1;
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    always_comb begin
        case (op)
            OP_SLL:  shift_step = {shreg[WIDTH-2:0], 1'b0};
            OP_SRA:  shift_step = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
            default: shift_step = {1'b0, shreg[WIDTH-1:1]};
        endcase
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            result  <= '0;
            zero    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            shreg   <= '0;
            cnt     <= '0;
            op      <= OP_ADD;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        illegal <= is_illegal;
`ifndef ALU_BARREL_SHIFT_EN
                        if (is_shift && shamt != '0) begin
                            shreg <= src_a;
                            cnt   <= shamt;
                            op    <= op_e'(alu_control);
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end else begin
                            result <= comb_res;
                            zero   <= (comb_res == '0);
                            done   <= 1'b1;
                            state  <= DONE;
                        end
`else
                        result <= comb_res;
                        zero   <= (comb_res == '0);
                        done   <= 1'b1;
                        state  <= DONE;
`endif
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                // result is written only on the last step so partial shifts never show.
                SHIFT: begin
                    shreg <= shift_step;
                    cnt   <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        result <= shift_step;
                        zero   <= (shift_step == '0);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; expected values are hand-computed constants.
// Build with ALU_BARREL_SHIFT_EN defined to check the barrel-shifter latency instead.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
    logic        illegal;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .result      (result),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit exp_ill,
                          input bit hammer);
        bit          is_sh;
        int          exp_lat;
        int          exp_busy;
        int          lat;
        int          busy_cyc;
        bit          seen;
        is_sh = (code == 4'b0010) || (code == 4'b0110) || (code == 4'b0111);
`ifdef ALU_BARREL_SHIFT_EN
        exp_lat  = 1;
        exp_busy = 0;
`else
        exp_lat  = is_sh ? int'(b[4:0]) + 1 : 1;
        exp_busy = is_sh ? int'(b[4:0]) : 0;
`endif
        start = 1'b1; alu_control = code; src_a = a; src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0; alu_control = 4'hF; src_a = ~a; src_b = ~b;
        lat = 0; busy_cyc = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hammer) begin
                start = 1'b1; alu_control = 4'b0000; src_a = $urandom; src_b = $urandom;
            end
            if (busy) busy_cyc++;
            if (done) begin
                lat  = i + 1;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check($sformatf("%s.timeout", tag), 32'd0, 32'd1);
        end else begin
            check($sformatf("%s.result", tag), result, exp);
            check($sformatf("%s.zero", tag), {31'd0, zero}, {31'd0, (exp == 32'd0)});
            check($sformatf("%s.illegal", tag), {31'd0, illegal}, {31'd0, exp_ill});
            check($sformatf("%s.latency", tag), lat, exp_lat);
            check($sformatf("%s.busy_cycles", tag), busy_cyc, exp_busy);
        end
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s.done_pulse", tag), {31'd0, done}, 32'd0);
        check($sformatf("%s.hold", tag), result, exp);
    endtask

    initial begin
        int dones;
        reset = 1'b1; start = 1'b0; alu_control = '0; src_a = '0; src_b = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst.result", result, 32'd0);
        check("rst.flags", {27'd0, zero, busy, done, illegal}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add",     4'b0000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0);
        run_op("sub_eq",  4'b0001, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0);
        run_op("add_wrap",4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
        run_op("slt_neg", 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sltu_big",4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
        run_op("slt_pos", 4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
        run_op("sltu_sm", 4'b0100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("xor",     4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0);
        run_op("or",      4'b1000, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
        run_op("and",     4'b1001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
        run_op("sra4",    4'b0110, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0);
        run_op("srl4",    4'b0111, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0);
        run_op("sll31",   4'b0010, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0);
        run_op("sll0",    4'b0010, 32'hABCD_0123, 32'h0000_0020, 32'hABCD_0123, 1'b0, 1'b0);
        run_op("sra_pos", 4'b0110, 32'h4000_0000, 32'h0000_0003, 32'h0800_0000, 1'b0, 1'b0);
        run_op("srl1",    4'b0111, 32'hFFFF_FFFF, 32'h0000_0021, 32'h7FFF_FFFF, 1'b0, 1'b0);
        run_op("hammer",  4'b0110, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b1);

        // Reset two cycles into a shamt=10 shift.
        start = 1'b1; alu_control = 4'b0010; src_a = 32'h0000_0001; src_b = 32'h0000_000A;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
`ifdef ALU_BARREL_SHIFT_EN
        check("midrst.busy_before", {31'd0, busy}, 32'd0);
        check("midrst.result_before", result, 32'h0000_0400);
`else
        check("midrst.busy_before", {31'd0, busy}, 32'd1);
        check("midrst.result_before", result, 32'hF800_0000);
`endif
        reset = 1'b1;
        #1;
        check("midrst.result", result, 32'd0);
        check("midrst.flags", {27'd0, zero, busy, done, illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst.no_done", dones, 0);

        run_op("illegal", 4'b1011, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        check("illegal.sticky", {31'd0, illegal}, 32'd1);
        run_op("clr_ill", 4'b0000, 32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
